// File: rtl/regfile_param.sv
// regfile_param
//   Parametrised register file: DEPTH entries of WIDTH bits, two
//   combinational read ports and one synchronous write port. After every
//   reset a sequential clear engine zeroes one entry per clock, so the
//   storage array itself carries no reset and can map onto plain memory.
//
//   State table:
//     state | meaning
//     CLEAR | clear engine walking cnt over every entry; writes ignored
//     READY | normal operation; writes accepted
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   we_i      in   write enable
//   waddr_i   in   write address (AW bits)
//   wdata_i   in   write data (WIDTH bits)
//   raddr1_i  in   read port 1 address
//   raddr2_i  in   read port 2 address
//   rdata1_o  out  read port 1 data (combinational)
//   rdata2_o  out  read port 2 data (combinational)
//   busy_o    out  clear in progress
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr1_i,
  input  logic [AW-1:0]    raddr2_i,
  output logic [WIDTH-1:0] rdata1_o,
  output logic [WIDTH-1:0] rdata2_o,
  output logic             busy_o
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= CLEAR;
      cnt    <= '0;
      busy_o <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(DEPTH - 1)) begin
            state  <= READY;
            busy_o <= 1'b0;
          end
        end
        READY: begin
          busy_o <= 1'b0;
        end
        default: begin
          state  <= CLEAR;
          cnt    <= '0;
          busy_o <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset of its own; the clear engine owns the write port
  // while in CLEAR, and a reset edge leaves the contents untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else if (we_i && !(ZERO_REG && waddr_i == '0)) begin
        mem[waddr_i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata1_o = mem[raddr1_i];
    if (busy_o) begin
      rdata1_o = '0;
    end else if (ZERO_REG && raddr1_i == '0) begin
      rdata1_o = '0;
    end else if (BYPASS && we_i && raddr1_i == waddr_i) begin
      rdata1_o = wdata_i;
    end
  end

  always_comb begin
    rdata2_o = mem[raddr2_i];
    if (busy_o) begin
      rdata2_o = '0;
    end else if (ZERO_REG && raddr2_i == '0) begin
      rdata2_o = '0;
    end else if (BYPASS && we_i && raddr2_i == waddr_i) begin
      rdata2_o = wdata_i;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param
//   Drives two register files from the same stimulus: one with hardwired
//   zero entry and bypass, one with neither. A per-instance array model
//   predicts every read from the architectural rules.
module tb_regfile_param;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic [W-1:0]  rd1_a, rd2_a, rd1_b, rd2_b;
  logic          busy_a, busy_b;

  regfile_param #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_zb (
    .clk      (clk),
    .reset    (reset),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .raddr1_i (raddr1),
    .raddr2_i (raddr2),
    .rdata1_o (rd1_a),
    .rdata2_o (rd2_a),
    .busy_o   (busy_a)
  );

  regfile_param #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut_plain (
    .clk      (clk),
    .reset    (reset),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .raddr1_i (raddr1),
    .raddr2_i (raddr2),
    .rdata1_o (rd1_b),
    .rdata2_o (rd2_b),
    .busy_o   (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] mdl_a [D];
  logic [W-1:0] mdl_b [D];
  bit           exp_busy;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_rd(input bit zr, input bit byp, input logic [AW-1:0] a,
                                          input logic [W-1:0] m [D]);
    if (exp_busy) return '0;
    if (zr && a == 0) return '0;
    if (byp && we && a == waddr) return wdata;
    return m[a];
  endfunction

  task automatic check_reads(input string tag);
    check_val({tag, "_a1"}, rd1_a, exp_rd(1'b1, 1'b1, raddr1, mdl_a));
    check_val({tag, "_a2"}, rd2_a, exp_rd(1'b1, 1'b1, raddr2, mdl_a));
    check_val({tag, "_b1"}, rd1_b, exp_rd(1'b0, 1'b0, raddr1, mdl_b));
    check_val({tag, "_b2"}, rd2_b, exp_rd(1'b0, 1'b0, raddr2, mdl_b));
    check_val({tag, "_busy_a"}, W'(busy_a), W'(exp_busy));
    check_val({tag, "_busy_b"}, W'(busy_b), W'(exp_busy));
  endtask

  // One rising edge; the model commits a write only if the file was ready.
  task automatic do_edge();
    @(posedge clk);
    if (!exp_busy && !reset && we) begin
      if (waddr != 0) mdl_a[waddr] = wdata;
      mdl_b[waddr] = wdata;
    end
    #1;
  endtask

  task automatic assert_reset(input int ncyc);
    reset = 1'b1;
    we    = 1'b0;
    exp_busy = 1'b1;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      check_val("busy_in_reset_a", W'(busy_a), 1);
      check_val("busy_in_reset_b", W'(busy_b), 1);
    end
    reset = 1'b0;
    for (int i = 0; i < D; i++) begin
      mdl_a[i] = '0;
      mdl_b[i] = '0;
    end
  endtask

  // Counts edges after release until busy drops; optional write noise
  // must be ignored by the file.
  task automatic run_clear(input string tag, input bit noise, input int limit_edges);
    int n;
    n = 0;
    while (n < 200 && n < limit_edges) begin
      if (noise) begin
        we    = 1'b1;
        waddr = AW'($urandom);
        wdata = $urandom | 32'h1;
      end
      raddr1 = AW'($urandom);
      raddr2 = AW'($urandom);
      #1;
      check_reads({tag, "_during"});
      do_edge();
      n++;
      if (!busy_a) break;
    end
    we = 1'b0;
    if (n < limit_edges) begin
      exp_busy = 1'b0;
      check_val({tag, "_clear_edges"}, W'(n), W'(D));
      check_val({tag, "_busy_b_low"}, W'(busy_b), 0);
    end
  endtask

  task automatic sweep(input string tag);
    we = 1'b0;
    for (int i = 0; i < D; i++) begin
      raddr1 = AW'(i);
      raddr2 = AW'(D - 1 - i);
      #1;
      check_reads(tag);
    end
  endtask

  task automatic write_one(input logic [AW-1:0] a, input logic [W-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    do_edge();
    we = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    exp_busy = 1'b1;

    // Reset held 3 cycles, then a full clear.
    assert_reset(3);
    run_clear("init", 1'b0, 1000);
    sweep("init_zero");

    // Random single writes, read back on both ports after the edge.
    for (int it = 0; it < 50; it++) begin
      a = AW'($urandom_range(1, D - 1));
      d = $urandom;
      we = 1'b1; waddr = a; wdata = d; raddr1 = a; raddr2 = a;
      #1;
      check_reads("rnd_pre");
      do_edge();
      we = 1'b0;
      #1;
      check_val("rnd_a1", rd1_a, d);
      check_val("rnd_b2", rd2_b, d);
      check_reads("rnd_post");
    end
    sweep("rnd_shadow");

    // Mixed random traffic, including address 0, checked mid-cycle.
    for (int it = 0; it < 60; it++) begin
      we = 1'($urandom); waddr = AW'($urandom); wdata = $urandom;
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom);
      raddr2 = ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom);
      #1;
      check_reads("mix_pre");
      do_edge();
    end
    we = 1'b0;

    // Entry 0 write.
    we = 1'b1; waddr = '0; wdata = 32'hDEAD_BEEF; raddr1 = '0; raddr2 = '0;
    #1;
    check_val("zero_pre_a1", rd1_a, 32'h0);
    check_val("zero_pre_a2", rd2_a, 32'h0);
    do_edge();
    we = 1'b0;
    #1;
    check_val("zero_post_a1", rd1_a, 32'h0);
    check_val("zero_post_a2", rd2_a, 32'h0);
    check_val("zero_post_b1", rd1_b, 32'hDEAD_BEEF);
    check_val("zero_post_b2", rd2_b, 32'hDEAD_BEEF);

    // Bypass behaviour.
    write_one(5'd5, 32'h1111_1111);
    we = 1'b1; waddr = 5'd5; wdata = 32'h2222_2222; raddr1 = 5'd5; raddr2 = 5'd4;
    #1;
    check_val("byp_pre_a1", rd1_a, 32'h2222_2222);
    check_val("byp_pre_b1", rd1_b, 32'h1111_1111);
    do_edge();
    we = 1'b0;
    #1;
    check_val("byp_post_a1", rd1_a, 32'h2222_2222);
    check_val("byp_post_b1", rd1_b, 32'h2222_2222);

    // Independent ports.
    write_one(5'd3, 32'hA5A5_0003);
    write_one(5'd7, 32'h5A5A_0007);
    raddr1 = 5'd3; raddr2 = 5'd7;
    #1;
    check_val("dual_a1", rd1_a, 32'hA5A5_0003);
    check_val("dual_a2", rd2_a, 32'h5A5A_0007);
    check_val("dual_b1", rd1_b, 32'hA5A5_0003);
    check_val("dual_b2", rd2_b, 32'h5A5A_0007);
    raddr1 = 5'd7; raddr2 = 5'd3;
    #1;
    check_val("swap_a1", rd1_a, 32'h5A5A_0007);
    check_val("swap_a2", rd2_a, 32'hA5A5_0003);
    check_val("swap_b1", rd1_b, 32'h5A5A_0007);
    check_val("swap_b2", rd2_b, 32'hA5A5_0003);

    // Preload every entry, then a one-cycle reset with write noise in the clear.
    for (int i = 0; i < D; i++) write_one(AW'(i), $urandom | 32'h8000_0000);
    sweep("preload");
    assert_reset(1);
    run_clear("pulse", 1'b1, 1000);
    sweep("pulse_zero");

    // Reset reasserted ten edges into a clear.
    for (int i = 0; i < D; i++) write_one(AW'(i), $urandom | 32'h1);
    assert_reset(1);
    run_clear("mid_first", 1'b1, 10);
    check_val("mid_still_busy", W'(busy_a), 1);
    assert_reset(1);
    run_clear("mid_second", 1'b1, 1000);
    sweep("mid_zero");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
